ps2_kbd_ascii: RTL and testbench
================================

# ps2_kbd_ascii

PS/2 keyboard receiver and scan-code decoder that drives the typing game's keyboard inputs. It deserialises PS/2 device-to-host frames and tracks make/break/extended prefixes. It translates set-2 make codes into ASCII and presents them as `kbd_ascii` plus a 2-bit key `state`, which is the interface the game logic polls.

## Interface
- `TIMEOUT`, default 50000: clk cycles without a ps2_clk falling edge before a partial frame is discarded (1 ms at 50 MHz).
- `clk`  in  1  system clock, 50 MHz.
- `clrn`  in  1  asynchronous active-low reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous to `clk`.
- `ps2_data`  in  1  raw PS/2 data, asynchronous to `clk`.
- `kbd_ascii`  out  8  ASCII of last accepted make code; 0x00 if unmapped.
- `scan_code`  out  8  last accepted make code (set 2, non-extended).
- `state`  out  2  00 no key held; 01 key held; 10 frame error; 11 unused.
- `key_valid`  out  1  one-cycle pulse on each newly accepted make.

## Operation
- **Input synchronisation.** `ps2_clk` and `ps2_data` each pass through 2 flops. A third `ps2_clk` flop detects falling edges. Data is sampled on the detected edge.
- **Frame format.** 11 bits, LSB first: start, 8 data, parity, stop. The frame is accepted only if start=0, stop=1 and parity is odd over data+parity.
  - Any check failure: `state`<=10, byte dropped, prefix FSM returns to IDLE.
  - `state` stays 10 until the next good frame is accepted.
- **Bit counter.** 0..10, cleared after bit 10. It is also cleared when the idle counter reaches `TIMEOUT`-1 with the bit counter nonzero. A timeout does not set the error state.
- **Prefix FSM.** States IDLE, BRK, EXT, EXT_BRK. Each accepted byte is handled as follows:
  - IDLE: byte F0 -> BRK; byte E0 -> EXT; other bytes are a make, stay in IDLE.
  - BRK: byte is a break code -> IDLE.
  - EXT: byte F0 -> EXT_BRK; other bytes -> IDLE, ignored.
  - EXT_BRK: any byte -> IDLE, ignored.
  - Extended keys never change any output.
- **Make handling.**
  - If the code equals the held `scan_code` and `state`=01, it is a typematic repeat: no pulse and no output change.
  - Otherwise `scan_code`<=code, `kbd_ascii`<=map(code), `state`<=01, and `key_valid` pulses.
- **Break handling.**
  - Break of the held `scan_code`: `state`<=00. `kbd_ascii` and `scan_code` are retained.
  - Break of any other code: ignored.
- **ASCII map.**
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a..z (0x61..0x7A).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
  - 29 -> 0x20, 5A -> 0x0D, 66 -> 0x08.
  - Every other code maps to 0x00. An unmapped make still pulses `key_valid`.

## Timing
- **Reset values.** `kbd_ascii`=0, `scan_code`=0, `state`=00, `key_valid`=0, FSM=IDLE, bit and idle counters 0. Reset mid-frame discards the partial frame.
- **Edge detection.** A ps2_clk falling edge is detected on the 3rd clk edge after the pin goes low.
- **Output latency.** Outputs and `key_valid` update on the clk edge immediately following detection of the stop-bit edge. Total latency is 4 clk cycles from the pin transition.
- **Pulse width.** `key_valid` is high for exactly 1 cycle.
- **Counter tie.** A ps2_clk edge arriving in the same cycle the idle counter hits `TIMEOUT`-1: the edge wins and the counter restarts.
- **Glitches.** ps2_clk glitches shorter than 1 clk period may be missed. No digital filter is required.

## Configuration
- **`PS2_SHIFT_EN` defined.**
  - The block tracks left shift (12) and right shift (59) as held/released flags. Their makes and breaks do not touch `scan_code`, `state` or `key_valid`.
  - While either flag is set, letters map to A..Z (0x41..0x5A). Digits are unaffected.
  - Reset clears both flags.
- **`PS2_SHIFT_EN` undefined.** 12 and 59 are ordinary unmapped codes. Letters are always lowercase.

## Test plan
- **Make then break.** Send frame 1C -> `key_valid` pulses once, `kbd_ascii`=0x61, `scan_code`=1C, `state`=01. Then send F0,1C -> `state`=00, `kbd_ascii` stays 0x61.
- **Typematic repeat.** Send 1C three times -> exactly one `key_valid` pulse. Then send 32 -> second pulse, `kbd_ascii`=0x62, `state`=01.
- **Parity error.** Send 1C with even parity -> `state`=10, no pulse, outputs otherwise unchanged. A following good 16 -> `state`=01, `kbd_ascii`=0x31.
- **Timeout.** Send 5 bits, idle for `TIMEOUT`+10 cycles, then send a full 29 frame -> `kbd_ascii`=0x20, no error.
- **Extended key and mid-frame reset.** Send E0,75,E0,F0,75 -> no output change. Pull `clrn` low mid-frame -> all outputs 0 immediately.
- **Shift (with `PS2_SHIFT_EN`).** Send 12, 1C -> `kbd_ascii`=0x41. Then F0,12, 1C -> no pulse (repeat of held code). Then F0,1C, 1C -> `kbd_ascii`=0x61.

Source files
------------

// File: rtl/ps2_kbd_ascii.sv
// PS/2 keyboard receiver with set-2 make/break decoding and ASCII translation.
// Optional left/right shift tracking is enabled by defining PS2_SHIFT_EN.
module ps2_kbd_ascii #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] kbd_ascii,
  output logic [7:0] scan_code,
  output logic [1:0] state,
  output logic       key_valid
);

  localparam int unsigned IdleW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IdleW-1:0] IdleMax = IdleW'(TIMEOUT - 1);

  localparam logic [1:0] KeyNone = 2'b00;
  localparam logic [1:0] KeyHeld = 2'b01;
  localparam logic [1:0] KeyErr  = 2'b10;

  typedef enum logic [1:0] {PfxIdle, PfxBrk, PfxExt, PfxExtBrk} pfx_e;

  logic [2:0]       clk_sync_q;
  logic [1:0]       dat_sync_q;
  logic             fall;
  logic             bit_in;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       sh_q;
  logic [IdleW-1:0] idle_q;
  logic             frame_rdy_q;
  logic             frame_ok_q;
  logic [7:0]       frame_byte_q;

  pfx_e       pfx_q, pfx_d;
  logic [7:0] kbd_d, scan_d;
  logic [1:0] state_d;
  logic       valid_d;
  logic       is_make, is_brk, is_shift, is_repeat;
  logic       shift_held;

  function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic upper);
    logic [7:0] ch;
    unique case (code)
      8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
      8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
      8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
      8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
      8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
      8'h29: ch = 8'h20; 8'h5A: ch = 8'h0D; 8'h66: ch = 8'h08;
      default: ch = 8'h00;
    endcase
    if (upper && ch >= 8'h61 && ch <= 8'h7A) ch = ch - 8'h20;
    return ch;
  endfunction

  // Sync flops reset high so an idle-high line never looks like a falling edge.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[1:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
    end
  end

  assign fall   = clk_sync_q[2] & ~clk_sync_q[1];
  assign bit_in = dat_sync_q[1];

  // sh_q collects start, data[7:0], parity; stop is checked as it arrives.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt_q    <= '0;
      sh_q         <= '0;
      idle_q       <= '0;
      frame_rdy_q  <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_byte_q <= '0;
    end else begin
      frame_rdy_q <= 1'b0;
      if (fall) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q    <= '0;
          frame_rdy_q  <= 1'b1;
          frame_ok_q   <= ~sh_q[0] & bit_in & (^sh_q[9:1]);
          frame_byte_q <= sh_q[8:1];
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          sh_q      <= {bit_in, sh_q[9:1]};
        end
      end else if (idle_q == IdleMax) begin
        idle_q    <= '0;
        bit_cnt_q <= '0;
      end else begin
        idle_q <= idle_q + IdleW'(1);
      end
    end
  end

`ifdef PS2_SHIFT_EN
  logic lsh_q, lsh_d, rsh_q, rsh_d;
  assign shift_held = lsh_q | rsh_q;
`else
  assign shift_held = 1'b0;
`endif

  always_comb begin
    pfx_d     = pfx_q;
    kbd_d     = kbd_ascii;
    scan_d    = scan_code;
    state_d   = state;
    valid_d   = 1'b0;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    is_shift  = 1'b0;
`ifdef PS2_SHIFT_EN
    lsh_d     = lsh_q;
    rsh_d     = rsh_q;
`endif
    if (frame_rdy_q) begin
      if (!frame_ok_q) begin
        state_d = KeyErr;
        pfx_d   = PfxIdle;
      end else begin
        unique case (pfx_q)
          PfxIdle: begin
            if (frame_byte_q == 8'hF0)      pfx_d = PfxBrk;
            else if (frame_byte_q == 8'hE0) pfx_d = PfxExt;
            else                            is_make = 1'b1;
          end
          PfxBrk: begin
            pfx_d  = PfxIdle;
            is_brk = 1'b1;
          end
          PfxExt:    pfx_d = (frame_byte_q == 8'hF0) ? PfxExtBrk : PfxIdle;
          PfxExtBrk: pfx_d = PfxIdle;
          default:   pfx_d = PfxIdle;
        endcase
      end
    end
`ifdef PS2_SHIFT_EN
    is_shift = (frame_byte_q == 8'h12) || (frame_byte_q == 8'h59);
    if (is_make && frame_byte_q == 8'h12) lsh_d = 1'b1;
    if (is_make && frame_byte_q == 8'h59) rsh_d = 1'b1;
    if (is_brk && frame_byte_q == 8'h12)  lsh_d = 1'b0;
    if (is_brk && frame_byte_q == 8'h59)  rsh_d = 1'b0;
`endif
    is_repeat = (frame_byte_q == scan_code) && (state == KeyHeld);
    if (is_make && !is_shift && !is_repeat) begin
      scan_d  = frame_byte_q;
      kbd_d   = ascii_map(frame_byte_q, shift_held);
      state_d = KeyHeld;
      valid_d = 1'b1;
    end
    if (is_brk && !is_shift && is_repeat) state_d = KeyNone;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pfx_q     <= PfxIdle;
      kbd_ascii <= '0;
      scan_code <= '0;
      state     <= KeyNone;
      key_valid <= 1'b0;
`ifdef PS2_SHIFT_EN
      lsh_q     <= 1'b0;
      rsh_q     <= 1'b0;
`endif
    end else begin
      pfx_q     <= pfx_d;
      kbd_ascii <= kbd_d;
      scan_code <= scan_d;
      state     <= state_d;
      key_valid <= valid_d;
`ifdef PS2_SHIFT_EN
      lsh_q     <= lsh_d;
      rsh_q     <= rsh_d;
`endif
    end
  end

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// Bench for ps2_kbd_ascii: keyboard-level model, per-cycle compare, directed frames.
// Shift cases are exercised when PS2_SHIFT_EN is defined.
module tb_ps2_kbd_ascii;

  localparam int unsigned TO = 200;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] kbd_ascii, scan_code;
  logic [1:0] state;
  logic       key_valid;

  ps2_kbd_ascii #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .kbd_ascii (kbd_ascii),
    .scan_code (scan_code),
    .state     (state),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit busy = 1'b1;
  int pulses = 0;
  int m_pulses = 0;
  bit kv_prev = 1'b0;
  int lat;

  // Keyboard model: what a typist would see.
  logic [7:0] m_kbd, m_scan;
  logic [1:0] m_state;
  bit m_brk, m_ext, m_lsh, m_rsh;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};

  function automatic logic [7:0] m_map(input logic [7:0] c, input bit up);
    for (int i = 0; i < 26; i++) if (letter_codes[i] == c) return up ? 8'(65 + i) : 8'(97 + i);
    for (int i = 0; i < 10; i++) if (digit_codes[i] == c) return 8'(48 + i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  function automatic bit m_is_shift(input logic [7:0] c);
`ifdef PS2_SHIFT_EN
    return c == 8'h12 || c == 8'h59;
`else
    return c == 8'hFF && c == 8'h00;
`endif
  endfunction

  task automatic m_reset();
    m_kbd = 8'h00; m_scan = 8'h00; m_state = 2'b00;
    m_brk = 0; m_ext = 0; m_lsh = 0; m_rsh = 0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_state = 2'b10; m_brk = 0; m_ext = 0;
    end else if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12) m_lsh = 0;
        else if (b == 8'h59) m_rsh = 0;
        if (!m_is_shift(b) && b == m_scan && m_state == 2'b01) m_state = 2'b00;
      end
      m_brk = 0; m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (m_ext) begin
      m_ext = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (m_is_shift(b)) begin
      if (b == 8'h12) m_lsh = 1; else m_rsh = 1;
    end else if (!(b == m_scan && m_state == 2'b01)) begin
      m_scan = b; m_kbd = m_map(b, m_lsh || m_rsh); m_state = 2'b01; m_pulses++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (clrn && !busy) begin
      chk("kbd_ascii", {24'd0, kbd_ascii}, {24'd0, m_kbd});
      chk("scan_code", {24'd0, scan_code}, {24'd0, m_scan});
      chk("state", {30'd0, state}, {30'd0, m_state});
      chk("key_valid idle", {31'd0, key_valid}, 32'd0);
    end
  end

  always @(negedge clk) begin
    if (clrn && key_valid) begin
      pulses++;
      chk("pulse width", {31'd0, kv_prev}, 32'd0);
    end
    kv_prev = key_valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic [10:0] f;
    f = {1'b1, ~^b, b, 1'b0};
    for (int i = 0; i < n; i++) begin
      ps2_data = f[i];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      wait_clk(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, output int l);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    l = 0;
    for (int i = 0; i < 11; i++) begin
      ps2_data = f[i];
      wait_clk(HALF);
      if (i == 10) busy = 1'b1;
      ps2_clk = 1'b0;
      for (int k = 1; k <= HALF; k++) begin
        @(posedge clk);
        #1;
        if (key_valid && l == 0) l = k;
      end
      ps2_clk = 1'b1;
    end
    wait_clk(4);
    m_byte(b, !bad_par);
    busy = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int l;
    send_frame(b, 1'b0, l);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    m_reset();
    wait_clk(3);
    chk("reset kbd_ascii", {24'd0, kbd_ascii}, 32'h0);
    chk("reset scan_code", {24'd0, scan_code}, 32'h0);
    chk("reset state", {30'd0, state}, 32'h0);
    chk("reset key_valid", {31'd0, key_valid}, 32'h0);
    clrn = 1'b1;
    wait_clk(3);
    busy = 1'b0;

    // Make then break
    send_frame(8'h1C, 1'b0, lat);
    chk("make latency", lat, 4);
    chk("make 1C ascii", {24'd0, kbd_ascii}, 32'h61);
    chk("make 1C scan", {24'd0, scan_code}, 32'h1C);
    chk("make 1C state", {30'd0, state}, 32'h1);
    chk("make 1C pulses", pulses, 1);
    send(8'hF0); send(8'h1C);
    chk("break 1C state", {30'd0, state}, 32'h0);
    chk("break 1C ascii kept", {24'd0, kbd_ascii}, 32'h61);

    // Typematic repeat
    send(8'h1C); send(8'h1C); send(8'h1C);
    chk("repeat pulses", pulses, 2);
    send(8'h32);
    chk("32 pulses", pulses, 3);
    chk("32 ascii", {24'd0, kbd_ascii}, 32'h62);
    chk("32 state", {30'd0, state}, 32'h1);

    // Parity error, then recovery
    send_frame(8'h1C, 1'b1, lat);
    chk("parity err no pulse", lat, 0);
    chk("parity err state", {30'd0, state}, 32'h2);
    chk("parity err ascii kept", {24'd0, kbd_ascii}, 32'h62);
    chk("parity err scan kept", {24'd0, scan_code}, 32'h32);
    send(8'h16);
    chk("16 state", {30'd0, state}, 32'h1);
    chk("16 ascii", {24'd0, kbd_ascii}, 32'h31);

    // Partial frame timeout
    send_bits(8'hA5, 5);
    wait_clk(TO + 10);
    send(8'h29);
    chk("timeout 29 ascii", {24'd0, kbd_ascii}, 32'h20);
    chk("timeout 29 state", {30'd0, state}, 32'h1);

    // Extended make/break leave outputs alone
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    chk("extended ascii", {24'd0, kbd_ascii}, 32'h20);
    chk("extended pulses", pulses, 5);

    // Unmapped make still pulses
    send(8'h76);
    chk("unmapped ascii", {24'd0, kbd_ascii}, 32'h00);
    chk("unmapped pulses", pulses, 6);

`ifdef PS2_SHIFT_EN
    send(8'hF0); send(8'h76);
    send(8'h12);
    chk("shift make no pulse", pulses, 6);
    send(8'h1C);
    chk("shifted a", {24'd0, kbd_ascii}, 32'h41);
    send(8'hF0); send(8'h12);
    send(8'h1C);
    chk("shift release repeat", pulses, 7);
    chk("shift release ascii", {24'd0, kbd_ascii}, 32'h41);
    send(8'hF0); send(8'h1C);
    send(8'h1C);
    chk("unshifted a", {24'd0, kbd_ascii}, 32'h61);
    chk("unshifted pulses", pulses, 8);
`else
    send(8'h12);
    chk("12 unmapped scan", {24'd0, scan_code}, 32'h12);
    chk("12 unmapped ascii", {24'd0, kbd_ascii}, 32'h00);
    send(8'h1C);
    chk("lowercase a", {24'd0, kbd_ascii}, 32'h61);
`endif
    chk("model pulse count", pulses, m_pulses);

    // Mid-frame reset
    send_bits(8'h1C, 4);
    clrn = 1'b0;
    #1;
    chk("midreset kbd_ascii", {24'd0, kbd_ascii}, 32'h0);
    chk("midreset scan_code", {24'd0, scan_code}, 32'h0);
    chk("midreset state", {30'd0, state}, 32'h0);
    chk("midreset key_valid", {31'd0, key_valid}, 32'h0);
    m_reset();
    wait_clk(3);
    clrn = 1'b1;
    wait_clk(3);
    send(8'h4D);
    chk("post reset ascii", {24'd0, kbd_ascii}, 32'h70);
    chk("post reset state", {30'd0, state}, 32'h1);
    chk("final pulse count", pulses, m_pulses);

    wait_clk(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
